// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock behind a
// start/busy/done handshake, with truncation overflow and a leading-zero mask.
module seq_bin_to_bcd #(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   decimal,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  overflow
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_q, shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_int_q, ovf_int_d;
  logic [SCR_W-1:0]     decimal_d;
  logic [DIGITS-1:0]    digit_valid_d;
  logic                 overflow_d;
  logic                 busy_d, done_d;

  logic [SCR_W-1:0]     adjusted;
  logic [SCR_W-1:0]     stepped;
  logic                 carry_out;
  logic [DIGITS-1:0]    stepped_valid;
  logic                 seen;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit
  always_comb begin
    adjusted = scratch_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
      end
    end
    carry_out = adjusted[SCR_W-1];
    stepped   = {adjusted[SCR_W-2:0], shift_q[BIN_WIDTH-1]};
  end

  // Significance mask scanned from the top digit down; ones digit always shown
  always_comb begin
    seen          = 1'b0;
    stepped_valid = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      seen = seen | (stepped[4*(int'(DIGITS)-1-i) +: 4] != 4'd0);
      stepped_valid[int'(DIGITS)-1-i] = seen;
    end
    stepped_valid[0] = 1'b1;
  end

  // Next-state and datapath control
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    scratch_d     = scratch_q;
    cnt_d         = cnt_q;
    ovf_int_d     = ovf_int_q;
    decimal_d     = decimal;
    digit_valid_d = digit_valid;
    overflow_d    = overflow;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SHIFT;
          shift_d   = binary;
          scratch_d = '0;
          cnt_d     = CNT_W'(BIN_WIDTH);
          ovf_int_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        scratch_d = stepped;
        cnt_d     = cnt_q - CNT_W'(1);
        ovf_int_d = ovf_int_q | carry_out;
        if (cnt_q == CNT_W'(1)) begin
          state_d       = DONE;
          decimal_d     = stepped;
          digit_valid_d = stepped_valid;
          overflow_d    = ovf_int_q | carry_out;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_int_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      decimal     <= '0;
      digit_valid <= DIGITS'(1);
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      ovf_int_q   <= ovf_int_d;
      busy        <= busy_d;
      done        <= done_d;
      decimal     <= decimal_d;
      digit_valid <= digit_valid_d;
      overflow    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench for seq_bin_to_bcd: three parameterisations driven with random
// start/binary traffic, checked against a decimal-arithmetic reference model.
module tb_seq_bin_to_bcd;

  typedef struct packed {
    logic [23:0] dec;
    logic [5:0]  dv;
    logic        ovf;
    logic [31:0] t;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin0 = '0, bin1 = '0;
  logic [16:0] bin2 = '0;
  logic        busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [11:0] dec0;
  logic [7:0]  dec1;
  logic [23:0] dec2;
  logic [2:0]  dv0;
  logic [1:0]  dv1;
  logic [5:0]  dv2;

  exp_t        q0[$], q1[$], q2[$];
  logic [16:0] d0[$] = '{17'd255, 17'd0, 17'd7};
  logic [16:0] d1[$] = '{17'd123, 17'd99, 17'd100, 17'd0, 17'd255};
  logic [16:0] d2[$] = '{17'd99999, 17'd131071, 17'd100000, 17'd0};

  int   checks = 0;
  int   passed = 0;
  int   next_ok[3] = '{0, 0, 0};
  int   last_acc[3] = '{0, 0, 0};
  bit   have_acc[3] = '{1'b0, 1'b0, 1'b0};
  bit   alt = 1'b0;

  seq_bin_to_bcd #(.BIN_WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start0), .binary(bin0), .busy(busy0),
    .done(done0), .decimal(dec0), .digit_valid(dv0), .overflow(ovf0));
  seq_bin_to_bcd #(.BIN_WIDTH(8), .DIGITS(2)) dut_trunc (
    .clk(clk), .reset(reset), .start(start1), .binary(bin1), .busy(busy1),
    .done(done1), .decimal(dec1), .digit_valid(dv1), .overflow(ovf1));
  seq_bin_to_bcd #(.BIN_WIDTH(17), .DIGITS(6)) dut_wide (
    .clk(clk), .reset(reset), .start(start2), .binary(bin2), .busy(busy2),
    .done(done2), .decimal(dec2), .digit_valid(dv2), .overflow(ovf2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wid(input int k);
    return (k == 2) ? 17 : 8;
  endfunction

  function automatic int digs(input int k);
    return (k == 0) ? 3 : (k == 1) ? 2 : 6;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected result from plain decimal arithmetic
  function automatic exp_t model(input int k, input logic [16:0] v, input int t);
    exp_t e;
    longint unsigned val, m, x;
    val = v;
    m = val % pow10(digs(k));
    x = m;
    e = '0;
    e.t = 32'(t);
    e.v = v;
    for (int d = 0; d < digs(k); d++) begin
      e.dec[4*d +: 4] = 4'(x % 10);
      x = x / 10;
      e.dv[d] = (d == 0) || (m >= pow10(d));
    end
    e.ovf = (val >= pow10(digs(k)));
    return e;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s dut%0d cyc=%0d: got 0x%0h, expected 0x%0h", nm, k, cyc, act, req);
  endtask

  // One stimulus cycle; the model decides which edges the DUT accepts
  task automatic step(input logic [2:0] en, input logic hold0, input int fval0);
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin : per_dut
      logic        st;
      logic [16:0] v;
      int          e;
      e  = cyc + 1;
      st = (k == 0 && hold0) ? 1'b1 : (en[k] && ($urandom_range(0, 3) == 0));
      v  = (k == 2) ? 17'($urandom) : {9'd0, 8'($urandom)};
      if (st && e >= next_ok[k]) begin
        if (k == 0 && fval0 == -2) begin
          v = alt ? 17'd59 : 17'd42;
          alt = ~alt;
        end else if (k == 0 && fval0 >= 0) begin
          v = 17'(fval0);
        end else begin
          case (k)
            0: if (d0.size() > 0) v = d0.pop_front();
            1: if (d1.size() > 0) v = d1.pop_front();
            default: if (d2.size() > 0) v = d2.pop_front();
          endcase
        end
        case (k)
          0: q0.push_back(model(k, v, e));
          1: q1.push_back(model(k, v, e));
          default: q2.push_back(model(k, v, e));
        endcase
        next_ok[k]  = e + wid(k) + 1;
        last_acc[k] = e;
        have_acc[k] = 1'b1;
      end
      case (k)
        0: begin start0 = st; bin0 = 8'(v); end
        1: begin start1 = st; bin1 = 8'(v); end
        default: begin start2 = st; bin2 = v; end
      endcase
    end
  endtask

  task automatic mon(input int k, input logic b, input logic d, input logic [23:0] dec,
                     input logic [5:0] dv, input logic o);
    exp_t f;
    logic have, exp_d, exp_b;
    have = 1'b0;
    f = '0;
    case (k)
      0: if (q0.size() > 0) begin f = q0[0]; have = 1'b1; end
      1: if (q1.size() > 0) begin f = q1[0]; have = 1'b1; end
      default: if (q2.size() > 0) begin f = q2[0]; have = 1'b1; end
    endcase
    exp_d = have && (int'(f.t) + wid(k) == cyc);
    exp_b = have_acc[k] && (cyc >= last_acc[k]) && (cyc < last_acc[k] + wid(k));
    chk("busy", k, 32'(b), 32'(exp_b));
    chk("done", k, 32'(d), 32'(exp_d));
    if (exp_d) begin
      case (k)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
      if (d) begin
        chk("decimal", k, 32'(dec), 32'(f.dec));
        chk("digit_valid", k, 32'(dv), 32'(f.dv));
        chk("overflow", k, 32'(o), 32'(f.ovf));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, busy0, done0, 24'(dec0), 6'(dv0), ovf0);
      mon(1, busy1, done1, 24'(dec1), 6'(dv1), ovf1);
      mon(2, busy2, done2, dec2, dv2, ovf2);
    end
  end

  task automatic check_reset_state();
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_done", 0, 32'(done0), 32'd0);
    chk("rst_decimal", 0, 32'(dec0), 32'd0);
    chk("rst_digit_valid", 0, 32'(dv0), 32'd1);
    chk("rst_overflow", 0, 32'(ovf0), 32'd0);
    chk("rst_busy", 1, 32'(busy1), 32'd0);
    chk("rst_decimal", 1, 32'(dec1), 32'd0);
    chk("rst_digit_valid", 1, 32'(dv1), 32'd1);
    chk("rst_busy", 2, 32'(busy2), 32'd0);
    chk("rst_done", 2, 32'(done2), 32'd0);
    chk("rst_decimal", 2, 32'(dec2), 32'd0);
    chk("rst_digit_valid", 2, 32'(dv2), 32'd1);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    #1 reset = 1'b0;

    // Random traffic; directed values are used for the first accepts
    repeat (300) step(3'b111, 1'b0, -1);
    // Start held high on the default instance, binary alternating 42/59
    repeat (60) step(3'b110, 1'b1, -2);
    repeat (20) step(3'b000, 1'b0, -1);

    // Abort a conversion of 200 after four steps with an asynchronous reset
    step(3'b000, 1'b1, 200);
    repeat (4) step(3'b000, 1'b0, -1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_state();
    q0.delete();
    q1.delete();
    q2.delete();
    for (int k = 0; k < 3; k++) begin
      have_acc[k] = 1'b0;
      next_ok[k]  = 0;
    end
    @(negedge clk);
    #1 reset = 1'b0;
    step(3'b000, 1'b1, 200);
    repeat (40) step(3'b000, 1'b0, -1);

    chk("pending", 0, 32'(q0.size()), 32'd0);
    chk("pending", 1, 32'(q1.size()), 32'd0);
    chk("pending", 2, 32'(q2.size()), 32'd0);
    chk("directed_left", 0, 32'(d0.size() + d1.size() + d2.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
